mtr_ramp_ctrl: RTL and testbench
================================

Name: mtr_ramp_ctrl

Overview:
- Slew-rate scheduler that drives the signed 11-bit left/right speed inputs of the motor PWM driver.
- Accepts target-speed commands over a valid/ready handshake and ramps each wheel toward its target by a bounded step per ramp tick.
- Emergency stop overrides everything, ramps both wheels to zero at a faster brake rate, and reports completion.
- Sits between the navigation/command logic and the motor driver.

Parameters:
- RAMP_DIV, 512, clock cycles per ramp tick; minimum 1.
- STEP, 8, maximum magnitude change per tick in normal ramping; range 1..1023.
- BRAKE_STEP, 32, maximum magnitude change per tick during emergency stop; range 1..1023.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_vld  in  1  new target pair valid.
- cmd_rdy  out  1  command accepted this cycle when cmd_vld & cmd_rdy.
- tgt_lft  in  11  signed target, left wheel.
- tgt_rght  in  11  signed target, right wheel.
- estop  in  1  level emergency stop request.
- lft_spd  out  11  signed registered left speed to the motor driver.
- rght_spd  out  11  signed registered right speed to the motor driver.
- at_tgt  out  1  registered; both speeds equal the latched targets and state is IDLE.
- brake_done  out  1  registered; in BRAKE with both speeds 0.

Behaviour:
- Reset, synchronous on rst_n=0: state=IDLE; lft_spd=rght_spd=0; latched targets=0; tick_cnt=0; at_tgt=1; brake_done=0. Reset mid-ramp or mid-brake forces outputs to 0 on the next edge.
- cmd_rdy is combinational: 1 when state!=BRAKE and estop=0.
- Target clamp: accepted targets are saturated to [-1023, +1023]. An input of -1024 latches as -1023.
- Tick counter:
  - Counts 0..RAMP_DIV-1 while in RAMP or BRAKE; tick=1 when tick_cnt==RAMP_DIV-1, then wraps to 0.
  - Held at 0 in IDLE.
  - Cleared to 0 on any command acceptance and on entry to BRAKE.
  - The first step therefore occurs RAMP_DIV cycles after the accept or the estop edge.
- Step rule, per side, on tick:
  - d = tgt - cur, computed at 12-bit signed width.
  - If |d| <= S: cur <= tgt.
  - Otherwise: cur <= cur + sign(d)*S.
  - S = STEP in RAMP, BRAKE_STEP in BRAKE. Results never leave [-1023, +1023].
- States:
  - IDLE: speeds hold. On accept, latch clamped targets, clear tick_cnt, at_tgt<=0, go to RAMP. If the accepted targets equal the current speeds, remain in IDLE and keep at_tgt=1.
  - RAMP: apply the step rule on each tick. On accept (retarget), latch the new targets and clear tick_cnt; the current speeds are kept, with no jump. When both post-step speeds equal the targets, go to IDLE and set at_tgt<=1 in the same edge.
  - BRAKE:
    - Entered from any state on the first cycle with estop=1. On entry, latched targets <= 0, tick_cnt <= 0, at_tgt <= 0.
    - Apply the step rule with BRAKE_STEP toward 0 on each tick.
    - brake_done <= 1 once both speeds are 0.
    - Exit to IDLE when both speeds are 0 and estop=0; brake_done <= 0 and at_tgt <= 1.
    - If estop stays high, remain in BRAKE at 0.
- Simultaneous cmd_vld=1 and estop=1: estop wins, cmd_rdy=0, and the command is dropped.
- lft_spd and rght_spd change only on tick edges or reset. There are no glitches and no combinational path from inputs to the speed outputs.

Test Plan (RAMP_DIV=4, STEP=16, BRAKE_STEP=64 unless noted):
- Reset, then accept tgt_lft=100, tgt_rght=-50 -> lft_spd steps 16,32,...,96,100 every 4 cycles. rght_spd steps -16,-32,-48,-50, reaches -50 first and holds. at_tgt=1 on the edge lft_spd becomes 100; cmd_rdy=1 throughout.
- Accept tgt_lft=-1024 -> latched target is -1023; ramp ends at lft_spd=-1023 (0x401), with no wrap past -1023.
- Retarget mid-ramp: at lft_spd=48, accept tgt_lft=0 -> tick_cnt restarts; 4 cycles later lft_spd=32, then 16, then 0, and at_tgt=1.
- From lft=rght=500, hold estop=1 -> cmd_rdy=0 immediately. Speeds step 436,372,...,52,0 every 4 cycles. brake_done=1 while estop is high. After estop drops, state=IDLE, at_tgt=1, speeds 0.
- cmd_vld=1 with tgt=200 in the same cycle estop rises -> command ignored; after brake and release, speeds remain 0.
- rst_n=0 for one cycle mid-ramp at lft_spd=64 -> next edge lft_spd=rght_spd=0, at_tgt=1, state IDLE, cmd_rdy=1.

Source files
------------

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate scheduler for the motor PWM driver: ramps left/right wheel speeds
// toward commanded targets by a bounded step per ramp tick, with an emergency-stop brake.
module mtr_ramp_ctrl #(
    parameter int RAMP_DIV   = 512,
    parameter int STEP       = 8,
    parameter int BRAKE_STEP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [10:0] tgt_lft,
    input  logic [10:0] tgt_rght,
    input  logic        estop,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        at_tgt,
    output logic        brake_done
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic signed [11:0] BRAKE_S = 12'(BRAKE_STEP);
    localparam logic signed [10:0] RAW_MIN = 11'h400;
    localparam logic signed [10:0] SPD_MIN = 11'h401;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        BRAKE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   tick_cnt, tick_cnt_n;
    logic signed [10:0] spd_l, spd_r, spd_l_n, spd_r_n;
    logic signed [10:0] tgt_l, tgt_r, tgt_l_n, tgt_r_n;
    logic               at_tgt_n, brake_done_n;
    logic               tick, accept;
    logic signed [10:0] cmd_l_sat, cmd_r_sat;
    logic signed [10:0] step_l, step_r;
    logic signed [11:0] step_sz;

    // The only 11-bit value outside the symmetric range is -1024.
    function automatic logic signed [10:0] sat_tgt(input logic signed [10:0] v);
        return (v == RAW_MIN) ? SPD_MIN : v;
    endfunction

    // Move cur toward tgt by at most s; the difference needs 12 bits to avoid wrap.
    function automatic logic signed [10:0] step_toward(
        input logic signed [10:0] cur,
        input logic signed [10:0] tgt,
        input logic signed [11:0] s
    );
        logic signed [11:0] cur_w, d, mag, nxt;
        cur_w = {cur[10], cur};
        d     = {tgt[10], tgt} - cur_w;
        mag   = d[11] ? -d : d;
        if (mag <= s) begin
            return tgt;
        end
        nxt = d[11] ? (cur_w - s) : (cur_w + s);
        return nxt[10:0];
    endfunction

    assign cmd_rdy   = (state != BRAKE) && !estop;
    assign accept    = cmd_vld && cmd_rdy;
    assign tick      = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign cmd_l_sat = sat_tgt(tgt_lft);
    assign cmd_r_sat = sat_tgt(tgt_rght);
    assign step_sz   = (state == BRAKE) ? BRAKE_S : STEP_S;
    assign step_l    = step_toward(spd_l, tgt_l, step_sz);
    assign step_r    = step_toward(spd_r, tgt_r, step_sz);

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        spd_l_n    = spd_l;
        spd_r_n    = spd_r;
        tgt_l_n    = tgt_l;
        tgt_r_n    = tgt_r;
        if (estop && (state != BRAKE)) begin
            state_n    = BRAKE;
            tgt_l_n    = '0;
            tgt_r_n    = '0;
            tick_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt_l_n    = cmd_l_sat;
                        tgt_r_n    = cmd_r_sat;
                        tick_cnt_n = '0;
                        if ((cmd_l_sat != spd_l) || (cmd_r_sat != spd_r)) begin
                            state_n = RAMP;
                        end
                    end
                end
                RAMP: begin
                    // A retarget keeps the current speeds and restarts the tick period.
                    if (accept) begin
                        tgt_l_n    = cmd_l_sat;
                        tgt_r_n    = cmd_r_sat;
                        tick_cnt_n = '0;
                    end else if (tick) begin
                        spd_l_n    = step_l;
                        spd_r_n    = step_r;
                        tick_cnt_n = '0;
                        if ((step_l == tgt_l) && (step_r == tgt_r)) begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                BRAKE: begin
                    if ((spd_l == '0) && (spd_r == '0) && !estop) begin
                        state_n    = IDLE;
                        tick_cnt_n = '0;
                    end else if (tick) begin
                        spd_l_n    = step_l;
                        spd_r_n    = step_r;
                        tick_cnt_n = '0;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    tick_cnt_n = '0;
                end
            endcase
        end
        at_tgt_n     = (state_n == IDLE) && (spd_l_n == tgt_l_n) && (spd_r_n == tgt_r_n);
        brake_done_n = (state_n == BRAKE) && (spd_l_n == '0) && (spd_r_n == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            spd_l      <= '0;
            spd_r      <= '0;
            tgt_l      <= '0;
            tgt_r      <= '0;
            at_tgt     <= 1'b1;
            brake_done <= 1'b0;
        end else begin
            tick_cnt   <= tick_cnt_n;
            spd_l      <= spd_l_n;
            spd_r      <= spd_r_n;
            tgt_l      <= tgt_l_n;
            tgt_r      <= tgt_r_n;
            at_tgt     <= at_tgt_n;
            brake_done <= brake_done_n;
        end
    end

    assign lft_spd  = spd_l;
    assign rght_spd = spd_r;

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// Bench for mtr_ramp_ctrl: directed vector table, hand-written latency/estop
// sequences, then randomized traffic against a behavioural speed-ramp model.
module tb_mtr_ramp_ctrl;

    localparam int RD = 4;
    localparam int ST = 16;
    localparam int BS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [10:0] tgt_lft;
    logic [10:0] tgt_rght;
    logic        estop;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        at_tgt;
    logic        brake_done;

    always #5 clk = ~clk;

    mtr_ramp_ctrl #(
        .RAMP_DIV  (RD),
        .STEP      (ST),
        .BRAKE_STEP(BS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .tgt_lft   (tgt_lft),
        .tgt_rght  (tgt_rght),
        .estop     (estop),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .at_tgt    (at_tgt),
        .brake_done(brake_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int sl();
        return int'($signed(lft_spd));
    endfunction

    function automatic int sr();
        return int'($signed(rght_spd));
    endfunction

    // Behavioural model: speeds, latched targets, cycles left until the next step.
    int m_l, m_r, m_tl, m_tr, m_wait;
    bit m_brk, m_mov, m_at, m_bd;

    function automatic int clampt(int v);
        return (v < -1023) ? -1023 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic int stepv(int c, int t, int s);
        int d;
        d = t - c;
        if (d <= s && d >= -s) return t;
        return (d > 0) ? c + s : c - s;
    endfunction

    always @(posedge clk) begin : model
        int tl, tr;
        tl = clampt(int'($signed(tgt_lft)));
        tr = clampt(int'($signed(tgt_rght)));
        if (!rst_n) begin
            m_l = 0; m_r = 0; m_tl = 0; m_tr = 0; m_wait = RD;
            m_brk = 0; m_mov = 0; m_at = 1; m_bd = 0;
        end else if (estop && !m_brk) begin
            m_brk = 1; m_mov = 0; m_tl = 0; m_tr = 0; m_wait = RD;
            m_at = 0; m_bd = (m_l == 0 && m_r == 0);
        end else if (m_brk) begin
            if (m_l == 0 && m_r == 0 && !estop) begin
                m_brk = 0; m_at = 1; m_bd = 0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_l = stepv(m_l, 0, BS);
                    m_r = stepv(m_r, 0, BS);
                    m_wait = RD;
                end
                m_bd = (m_l == 0 && m_r == 0);
            end
        end else if (cmd_vld) begin
            m_tl = tl; m_tr = tr; m_wait = RD;
            if (m_mov || tl != m_l || tr != m_r) begin
                m_mov = 1; m_at = 0;
            end else begin
                m_at = 1;
            end
        end else if (m_mov) begin
            m_wait--;
            if (m_wait == 0) begin
                m_l = stepv(m_l, m_tl, ST);
                m_r = stepv(m_r, m_tr, ST);
                m_wait = RD;
                if (m_l == m_tl && m_r == m_tr) begin
                    m_mov = 0; m_at = 1;
                end
            end
        end
    end

    typedef struct {
        bit rst_n;
        bit vld;
        int tl;
        int tr;
        bit es;
        int n;
        int el;
        int er;
        bit eat;
        bit ebd;
        bit erdy;
    } vec_t;

    vec_t vt[$];

    initial begin
        int tl, tr;
        rst_n    = 1'b0;
        cmd_vld  = 1'b0;
        estop    = 1'b0;
        tgt_lft  = '0;
        tgt_rght = '0;

        //                rst vld   tl     tr   es   n    el     er   at bd rdy
        vt.push_back(vec_t'{0, 0,     0,     0, 0,   1,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 1,   100,   -50, 0,   1,     0,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,    16,  -16, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,    32,  -32, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,    48,  -48, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,    64,  -50, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   8,    96,  -50, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,   100,  -50, 1, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   3,   100,  -50, 1, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 1,   1,   100,  -50, 0, 0, 0});
        vt.push_back(vec_t'{1, 0,     0,     0, 1,   4,    36,    0, 0, 0, 0});
        vt.push_back(vec_t'{1, 0,     0,     0, 1,   4,     0,    0, 0, 1, 0});
        vt.push_back(vec_t'{1, 0,     0,     0, 1,   4,     0,    0, 0, 1, 0});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   1,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 1, -1024,  1023, 0,   1,     0,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0, 256, -1023, 1023, 1, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 1,  65,     0,    0, 0, 1, 0});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   1,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 1,   100,     0, 0,   1,     0,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,  12,    48,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 1,     0,     0, 0,   1,    48,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,    32,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,    16,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 1,   200,   200, 1,   1,     0,    0, 0, 1, 0});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   1,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   8,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 1,   100,   100, 0,   1,     0,    0, 0, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,  16,    64,   64, 0, 0, 1});
        vt.push_back(vec_t'{0, 0,     0,     0, 0,   1,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   8,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 1,     0,     0, 0,   1,     0,    0, 1, 0, 1});
        vt.push_back(vec_t'{1, 0,     0,     0, 0,   4,     0,    0, 1, 0, 1});

        foreach (vt[k]) begin
            rst_n    = vt[k].rst_n;
            cmd_vld  = vt[k].vld;
            tgt_lft  = 11'(vt[k].tl);
            tgt_rght = 11'(vt[k].tr);
            estop    = vt[k].es;
            for (int c = 0; c < vt[k].n; c++) begin
                @(posedge clk);
                #1;
                cmd_vld = 1'b0;
                rst_n   = 1'b1;
            end
            chk($sformatf("vec%0d lft_spd", k), sl(), vt[k].el);
            chk($sformatf("vec%0d rght_spd", k), sr(), vt[k].er);
            chk($sformatf("vec%0d at_tgt", k), int'(at_tgt), int'(vt[k].eat));
            chk($sformatf("vec%0d brake_done", k), int'(brake_done), int'(vt[k].ebd));
            chk($sformatf("vec%0d cmd_rdy", k), int'(cmd_rdy), int'(vt[k].erdy));
        end

        // First step lands exactly RAMP_DIV edges after the accept edge.
        estop    = 1'b0;
        cmd_vld  = 1'b1;
        tgt_lft  = 11'(40);
        tgt_rght = 11'(-40);
        #1;
        chk("accept cmd_rdy", int'(cmd_rdy), 1);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        for (int c = 1; c <= RD; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("first_step edge%0d lft", c), sl(), (c == RD) ? 16 : 0);
            chk($sformatf("first_step edge%0d rght", c), sr(), (c == RD) ? -16 : 0);
        end

        // estop drops cmd_rdy combinationally and swallows a simultaneous command.
        estop = 1'b1;
        #1;
        chk("estop rdy immediate", int'(cmd_rdy), 0);
        cmd_vld  = 1'b1;
        tgt_lft  = 11'(200);
        tgt_rght = 11'(200);
        #1;
        chk("estop+vld rdy", int'(cmd_rdy), 0);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        chk("brake entry lft hold", sl(), 16);
        chk("brake entry done", int'(brake_done), 0);
        repeat (RD) @(posedge clk);
        #1;
        chk("brake lft zero", sl(), 0);
        chk("brake rght zero", sr(), 0);
        chk("brake done set", int'(brake_done), 1);
        estop = 1'b0;
        @(posedge clk);
        #1;
        chk("release at_tgt", int'(at_tgt), 1);
        chk("release done clr", int'(brake_done), 0);
        repeat (3 * RD) @(posedge clk);
        #1;
        chk("dropped cmd lft", sl(), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_vld = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 9))
                0:       tl = -1024;
                1:       tl = 1023;
                default: tl = int'($urandom_range(0, 400)) - 200;
            endcase
            case ($urandom_range(0, 9))
                0:       tr = -1024;
                1:       tr = 1023;
                default: tr = int'($urandom_range(0, 400)) - 200;
            endcase
            tgt_lft  = 11'(tl);
            tgt_rght = 11'(tr);
            if ($urandom_range(0, 59) == 0) estop = ~estop;
            rst_n = ($urandom_range(0, 799) != 0);
            #1;
            chk("rnd cmd_rdy", int'(cmd_rdy), int'(!m_brk && !estop));
            @(posedge clk);
            #1;
            chk("rnd lft_spd", sl(), m_l);
            chk("rnd rght_spd", sr(), m_r);
            chk("rnd at_tgt", int'(at_tgt), int'(m_at));
            chk("rnd brake_done", int'(brake_done), int'(m_bd));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
